// File: rtl/match_controller.sv
// ---------------------------------------------------------------------------
// match_controller
//
// Referee for a two-player paddle game. Tracks the score, freezes the ball
// before each serve, decides the serve direction, and holds a win screen
// before returning to idle.
//
// Parameters
//   WIN_SCORE    points needed to win the match (1..15)
//   SERVE_FRAMES frame ticks the ball stays frozen before each serve (1..255)
//   HOLD_FRAMES  frame ticks the win screen stays up (1..255)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   frame_tick  one-cycle pulse per video frame
//   start       debounced start request, honoured only in IDLE
//   point_p1    one-cycle pulse: player 1 scored
//   point_p2    one-cycle pulse: player 2 scored
//   winner      colour of the winning player, 3'b000 when there is none
//   score_p1    player 1 score
//   score_p2    player 2 score
//   game_active high only while the ball may move
//   serve_dir   0 = serve toward player 1, 1 = toward player 2
//   ball_reset  one-cycle pulse commanding the ball back to centre
// ---------------------------------------------------------------------------

`ifndef PLAYER_1_COLOR
`define PLAYER_1_COLOR 3'b100
`endif
`ifndef PLAYER_2_COLOR
`define PLAYER_2_COLOR 3'b001
`endif

module match_controller #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int HOLD_FRAMES  = 180
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       point_p1,
  input  logic       point_p2,
  output logic [2:0] winner,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       game_active,
  output logic       serve_dir,
  output logic       ball_reset
);

  localparam logic [3:0] WIN_VALUE  = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);
  localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE    = 2'd1,
    PLAY     = 2'd2,
    WIN_HOLD = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] frame_cnt;

  // Single registered FSM. frame_cnt counts the remaining frame ticks of
  // the current SERVE or WIN_HOLD period; the state advances on the tick
  // that would take it from 1 to 0, i.e. on the N-th tick after loading N.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      frame_cnt   <= 8'd0;
      winner      <= 3'b000;
      score_p1    <= 4'd0;
      score_p2    <= 4'd0;
      game_active <= 1'b0;
      serve_dir   <= 1'b0;
      ball_reset  <= 1'b0;
    end else begin
      ball_reset <= 1'b0;

      case (state)
        IDLE: begin
          game_active <= 1'b0;
          winner      <= 3'b000;
          if (start) begin
            state      <= SERVE;
            score_p1   <= 4'd0;
            score_p2   <= 4'd0;
            serve_dir  <= 1'b0;
            ball_reset <= 1'b1;
            frame_cnt  <= SERVE_LOAD;
          end
        end

        SERVE: begin
          if (frame_tick) begin
            if (frame_cnt <= 8'd1) begin
              state       <= PLAY;
              game_active <= 1'b1;
              frame_cnt   <= 8'd0;
            end else begin
              frame_cnt <= frame_cnt - 8'd1;
            end
          end
        end

        PLAY: begin
          // Simultaneous points cancel and the rally is replayed from the
          // same side; a lone point either wins or hands the serve over.
          if (point_p1 && point_p2) begin
            state       <= SERVE;
            game_active <= 1'b0;
            ball_reset  <= 1'b1;
            frame_cnt   <= SERVE_LOAD;
          end else if (point_p1) begin
            score_p1    <= score_p1 + 4'd1;
            game_active <= 1'b0;
            if (score_p1 + 4'd1 == WIN_VALUE) begin
              state     <= WIN_HOLD;
              winner    <= `PLAYER_1_COLOR;
              frame_cnt <= HOLD_LOAD;
            end else begin
              state      <= SERVE;
              serve_dir  <= 1'b1;
              ball_reset <= 1'b1;
              frame_cnt  <= SERVE_LOAD;
            end
          end else if (point_p2) begin
            score_p2    <= score_p2 + 4'd1;
            game_active <= 1'b0;
            if (score_p2 + 4'd1 == WIN_VALUE) begin
              state     <= WIN_HOLD;
              winner    <= `PLAYER_2_COLOR;
              frame_cnt <= HOLD_LOAD;
            end else begin
              state      <= SERVE;
              serve_dir  <= 1'b0;
              ball_reset <= 1'b1;
              frame_cnt  <= SERVE_LOAD;
            end
          end
        end

        WIN_HOLD: begin
          game_active <= 1'b0;
          if (frame_tick) begin
            if (frame_cnt <= 8'd1) begin
              state     <= IDLE;
              winner    <= 3'b000;
              frame_cnt <= 8'd0;
            end else begin
              frame_cnt <= frame_cnt - 8'd1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// ---------------------------------------------------------------------------
// tb_match_controller
//
// Self-checking bench for match_controller with WIN_SCORE=3, SERVE_FRAMES=2
// and HOLD_FRAMES=4. Directed scenario tasks check against constants; a
// randomized task checks every cycle against a behavioural match model.
// ---------------------------------------------------------------------------

`ifndef PLAYER_1_COLOR
`define PLAYER_1_COLOR 3'b100
`endif
`ifndef PLAYER_2_COLOR
`define PLAYER_2_COLOR 3'b001
`endif

module tb_match_controller;

  localparam int WIN   = 3;
  localparam int SERVE = 2;
  localparam int HOLD  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       point_p1 = 1'b0;
  logic       point_p2 = 1'b0;
  logic [2:0] winner;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       game_active;
  logic       serve_dir;
  logic       ball_reset;

  int check_count = 0;
  int pass_count  = 0;

  match_controller #(
    .WIN_SCORE(WIN),
    .SERVE_FRAMES(SERVE),
    .HOLD_FRAMES(HOLD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_tick(frame_tick),
    .start(start),
    .point_p1(point_p1),
    .point_p2(point_p2),
    .winner(winner),
    .score_p1(score_p1),
    .score_p2(score_p2),
    .game_active(game_active),
    .serve_dir(serve_dir),
    .ball_reset(ball_reset)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs; outputs are observed 1 time unit after the
  // capturing edge.
  task automatic cycle(input logic p1, input logic p2, input logic tick, input logic st);
    point_p1   = p1;
    point_p2   = p2;
    frame_tick = tick;
    start      = st;
    @(posedge clk);
    #1;
    point_p1   = 1'b0;
    point_p2   = 1'b0;
    frame_tick = 1'b0;
    start      = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Start a match and wait out the serve freeze so the ball is live.
  task automatic start_and_serve();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic serve_wait();
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    logic [14:0] got;
    start_and_serve();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    got = {winner, score_p1, score_p2, game_active, serve_dir, ball_reset};
    check_count++;
    if (got !== 15'd0) $display("[TB] FAIL reset_async got=%h want=0", got);
    else pass_count++;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
    got = {winner, score_p1, score_p2, game_active, serve_dir, ball_reset};
    check_count++;
    if (got !== 15'd0) $display("[TB] FAIL reset_stays_idle got=%h want=0", got);
    else pass_count++;
  endtask

  task automatic test_serve_timing();
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_count++;
    if ({ball_reset, game_active} !== 2'b10)
      $display("[TB] FAIL serve_pulse br/ga got=%b want=10", {ball_reset, game_active});
    else pass_count++;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_count++;
    if ({ball_reset, game_active} !== 2'b00)
      $display("[TB] FAIL serve_pulse_width br/ga got=%b want=00", {ball_reset, game_active});
    else pass_count++;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_count++;
    if (game_active !== 1'b0) $display("[TB] FAIL serve_early ga got=%b want=0", game_active);
    else pass_count++;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_count++;
    if (game_active !== 1'b1) $display("[TB] FAIL serve_active ga got=%b want=1", game_active);
    else pass_count++;
  endtask

  task automatic test_win_and_hold();
    do_reset();
    start_and_serve();
    for (int k = 1; k <= WIN; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check_count++;
      if (score_p1 !== 4'(k)) $display("[TB] FAIL win_score got=%0d want=%0d", score_p1, k);
      else pass_count++;
      if (k < WIN) begin
        check_count++;
        if ({ball_reset, serve_dir, game_active, winner} !== {3'b110, 3'b000})
          $display("[TB] FAIL win_midpoint br/dir/ga/win got=%b want=110000",
                   {ball_reset, serve_dir, game_active, winner});
        else pass_count++;
        serve_wait();
      end
    end
    check_count++;
    if ({winner, game_active, ball_reset} !== {`PLAYER_1_COLOR, 2'b00})
      $display("[TB] FAIL win_final win/ga/br got=%b want=%b",
               {winner, game_active, ball_reset}, {`PLAYER_1_COLOR, 2'b00});
    else pass_count++;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int t = 1; t <= HOLD; t++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      check_count++;
      if (t < HOLD) begin
        if (winner !== `PLAYER_1_COLOR || ball_reset !== 1'b0)
          $display("[TB] FAIL hold_tick%0d winner got=%b want=%b", t, winner, `PLAYER_1_COLOR);
        else pass_count++;
      end else begin
        if (winner !== 3'b000) $display("[TB] FAIL hold_end winner got=%b want=000", winner);
        else pass_count++;
      end
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check_count++;
    if ({score_p1, score_p2, game_active, ball_reset} !== {4'd3, 4'd0, 2'b00})
      $display("[TB] FAIL idle_scores got=%0d/%0d ga=%b br=%b want=3/0 0 0",
               score_p1, score_p2, game_active, ball_reset);
    else pass_count++;
  endtask

  task automatic test_tie_replay();
    do_reset();
    start_and_serve();
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check_count++;
    if ({score_p1, score_p2, ball_reset, game_active, serve_dir} !== {8'd0, 3'b100})
      $display("[TB] FAIL tie_replay s1=%0d s2=%0d br=%b ga=%b dir=%b want 0 0 1 0 0",
               score_p1, score_p2, ball_reset, game_active, serve_dir);
    else pass_count++;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check_count++;
    if ({score_p1, score_p2, game_active} !== 9'd0)
      $display("[TB] FAIL serve_ignores_points s1=%0d s2=%0d ga=%b want 0 0 0",
               score_p1, score_p2, game_active);
    else pass_count++;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_count++;
    if (game_active !== 1'b1) $display("[TB] FAIL tie_reserve ga got=%b want=1", game_active);
    else pass_count++;
  endtask

  task automatic test_mid_play_reset();
    do_reset();
    start_and_serve();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    serve_wait();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    serve_wait();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    serve_wait();
    check_count++;
    if ({score_p1, score_p2, game_active} !== {4'd2, 4'd1, 1'b1})
      $display("[TB] FAIL pre_reset s1=%0d s2=%0d ga=%b want 2 1 1", score_p1, score_p2, game_active);
    else pass_count++;
    #3;
    rst_n = 1'b0;
    #1;
    check_count++;
    if ({winner, score_p1, score_p2, game_active, serve_dir, ball_reset} !== 15'd0)
      $display("[TB] FAIL mid_play_reset got=%h want=0",
               {winner, score_p1, score_p2, game_active, serve_dir, ball_reset});
    else pass_count++;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      check_count++;
      if ({winner, score_p1, score_p2, game_active, serve_dir, ball_reset} !== 15'd0)
        $display("[TB] FAIL post_reset_quiet cyc%0d got=%h want=0", i,
                 {winner, score_p1, score_p2, game_active, serve_dir, ball_reset});
      else pass_count++;
    end
  endtask

  task automatic test_serve_dir();
    do_reset();
    start_and_serve();
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check_count++;
    if ({score_p2, serve_dir, ball_reset} !== {4'd1, 2'b01})
      $display("[TB] FAIL p2_point s2=%0d dir=%b br=%b want 1 0 1", score_p2, serve_dir, ball_reset);
    else pass_count++;
    serve_wait();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_count++;
    if ({score_p1, serve_dir} !== {4'd1, 1'b1})
      $display("[TB] FAIL p1_point s1=%0d dir=%b want 1 1", score_p1, serve_dir);
    else pass_count++;
  endtask

  // Behavioural model of a match: which phase the game is in, how many
  // frames remain in a timed phase, the score and who serves next.
  typedef enum {M_IDLE, M_FROZEN, M_RALLY, M_CELEBRATE} phase_t;

  task automatic test_random();
    phase_t      phase = M_IDLE;
    int          left = 0;
    int          s1 = 0, s2 = 0, dir = 0, win_color = 0, br;
    logic        p1, p2, tk, st;
    logic [14:0] want, got;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      p1 = ($urandom_range(0, 5) == 0);
      p2 = ($urandom_range(0, 5) == 0);
      tk = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 7) == 0);
      br = 0;
      case (phase)
        M_IDLE: if (st) begin
          s1 = 0; s2 = 0; dir = 0; br = 1; left = SERVE; phase = M_FROZEN;
        end
        M_FROZEN: if (tk) begin
          left = left - 1;
          if (left == 0) phase = M_RALLY;
        end
        M_RALLY: if (p1 && p2) begin
          br = 1; left = SERVE; phase = M_FROZEN;
        end else if (p1 || p2) begin
          if (p1) s1 = s1 + 1; else s2 = s2 + 1;
          if ((p1 ? s1 : s2) == WIN) begin
            win_color = p1 ? `PLAYER_1_COLOR : `PLAYER_2_COLOR;
            left = HOLD; phase = M_CELEBRATE;
          end else begin
            dir = p1 ? 1 : 0; br = 1; left = SERVE; phase = M_FROZEN;
          end
        end
        M_CELEBRATE: if (tk) begin
          left = left - 1;
          if (left == 0) phase = M_IDLE;
        end
      endcase
      want = {(phase == M_CELEBRATE) ? 3'(win_color) : 3'b000, 4'(s1), 4'(s2),
              phase == M_RALLY, 1'(dir), 1'(br)};
      cycle(p1, p2, tk, st);
      got = {winner, score_p1, score_p2, game_active, serve_dir, ball_reset};
      check_count++;
      if (got !== want) $display("[TB] FAIL random cyc%0d got=%b want=%b", n, got, want);
      else pass_count++;
    end
  endtask

  initial begin
    test_reset();
    test_serve_timing();
    test_win_and_hold();
    test_tie_replay();
    test_mid_play_reset();
    test_serve_dir();
    test_random();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
